// File: rtl/tdm_demultiplexer.sv
// Serial TDM receiver: steers slot k of each 4-slot frame onto out_k and strobes complete frames.
// Optional even-parity 5th slot when TDM_PARITY_EN is defined.
module tdm_demultiplexer (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic valid,
  input  logic sync,
  output logic out0,
  output logic out1,
  output logic out2,
  output logic out3,
  output logic frame_valid,
  output logic locked,
  output logic sync_err,
  output logic address0,
  output logic address1
);

`ifdef TDM_PARITY_EN
  localparam logic [2:0] LAST_SLOT = 3'd4;
`else
  localparam logic [2:0] LAST_SLOT = 3'd3;
`endif

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_slot, w_slot_nxt;
  logic [3:0]  r_sh, w_sh_nxt;
  logic [3:0]  r_out, w_out_nxt;
  logic        r_fv, w_fv_nxt;
  logic        r_err, w_err_nxt;
  logic        r_locked, w_locked_nxt;
  logic [1:0]  r_addr, w_addr_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= HUNT;
      r_slot   <= 3'd0;
      r_sh     <= 4'd0;
      r_out    <= 4'd0;
      r_fv     <= 1'b0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
      r_addr   <= 2'b00;
    end else begin
      r_state  <= w_state_nxt;
      r_slot   <= w_slot_nxt;
      r_sh     <= w_sh_nxt;
      r_out    <= w_out_nxt;
      r_fv     <= w_fv_nxt;
      r_err    <= w_err_nxt;
      r_locked <= w_locked_nxt;
      r_addr   <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_sh_nxt    = r_sh;
    w_out_nxt   = r_out;
    w_fv_nxt    = 1'b0;
    w_err_nxt   = 1'b0;

    if (valid) begin
      unique case (r_state)
        HUNT: begin
          if (sync) begin
            w_sh_nxt[0] = in;
            w_slot_nxt  = 3'd1;
            w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (sync) begin
            // A sync anywhere but slot 0 aborts the partial frame and restarts on this bit.
            w_err_nxt   = (r_slot != 3'd0);
            w_sh_nxt[0] = in;
            w_slot_nxt  = 3'd1;
          end else if (r_slot == 3'd0) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = HUNT;
            w_slot_nxt  = 3'd0;
          end else if (r_slot == LAST_SLOT) begin
`ifdef TDM_PARITY_EN
            if (in == ^r_sh) begin
              w_out_nxt = r_sh;
              w_fv_nxt  = 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
`else
            w_sh_nxt[3] = in;
            w_out_nxt   = {in, r_sh[2:0]};
            w_fv_nxt    = 1'b1;
`endif
            w_slot_nxt = 3'd0;
          end else begin
            w_sh_nxt[r_slot[1:0]] = in;
            w_slot_nxt            = r_slot + 3'd1;
          end
        end
        default: ;
      endcase
    end

    w_locked_nxt = (w_state_nxt == LOCKED);
    // Address reports the next data slot; the parity slot shows 00.
    w_addr_nxt   = (w_locked_nxt && (w_slot_nxt != 3'd4)) ? w_slot_nxt[1:0] : 2'b00;
  end

  assign out0        = r_out[0];
  assign out1        = r_out[1];
  assign out2        = r_out[2];
  assign out3        = r_out[3];
  assign frame_valid = r_fv;
  assign sync_err    = r_err;
  assign locked      = r_locked;
  assign address0    = r_addr[0];
  assign address1    = r_addr[1];

endmodule
